// File: rtl/fixed_to_float.sv
// Pipelined int32 -> IEEE-754 single converter, round to nearest even, global-stall AXI-Stream handshake.
// Four compute stages followed by LATENCY-4 delay registers so the total latency matches the IP it replaces.
module fixed_to_float #(
    parameter int SIZE    = 32,
    parameter int LATENCY = 7
) (
    input  logic            aclk,
    input  logic            aresetn,
    input  logic [SIZE-1:0] s_axis_a_tdata,
    input  logic            s_axis_a_tvalid,
    output logic            s_axis_a_tready,
    output logic [SIZE-1:0] m_axis_result_tdata,
    output logic            m_axis_result_tvalid,
    input  logic            m_axis_result_tready
);

    if (SIZE != 32) begin : g_bad_size
        $error("fixed_to_float: SIZE must be 32");
    end
    if (LATENCY < 4) begin : g_bad_latency
        $error("fixed_to_float: LATENCY must be >= 4");
    end

    function automatic logic [4:0] clz(input logic [31:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd0;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!found && v[i]) begin
                found = 1'b1;
                n     = 5'(31 - i);
            end
        end
        return n;
    endfunction

    // Carry out of the mantissa bumps the exponent; 159 is the largest reachable value.
    function automatic logic [31:0] round_pack(input logic s, input logic z,
                                               input logic [7:0] e, input logic [22:0] f,
                                               input logic g, input logic st);
        logic        up;
        logic [23:0] sum;
        logic [7:0]  e2;
        up  = g & (st | f[0]);
        sum = {1'b0, f} + {23'd0, up};
        e2  = e + {7'd0, sum[23]};
        if (z)
            return 32'h0000_0000;
        return {s, e2, sum[22:0]};
    endfunction

    logic        advance;
    logic [31:0] out_data;
    logic        out_vld;

    assign advance         = m_axis_result_tready || !m_axis_result_tvalid;
    assign s_axis_a_tready = advance;

    logic signed [31:0] x;
    logic [31:0]        mag_in;
    assign x      = s_axis_a_tdata;
    assign mag_in = x[31] ? 32'(-x) : 32'(x);

    logic        vld_p1, sign_p1, zero_p1;
    logic [31:0] mag_p1;
    logic        vld_p2, sign_p2, zero_p2;
    logic [31:0] mag_p2;
    logic [4:0]  lz_p2;
    logic        vld_p3, sign_p3, zero_p3, g_p3, st_p3;
    logic [7:0]  exp_p3;
    logic [22:0] frac_p3;
    logic        vld_p4;
    logic [31:0] res_p4;

    logic [30:0] norm;
    assign norm = 31'(mag_p2 << lz_p2);

    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            vld_p1  <= 1'b0;
            sign_p1 <= 1'b0;
            zero_p1 <= 1'b0;
            mag_p1  <= '0;
            vld_p2  <= 1'b0;
            sign_p2 <= 1'b0;
            zero_p2 <= 1'b0;
            mag_p2  <= '0;
            lz_p2   <= '0;
            vld_p3  <= 1'b0;
            sign_p3 <= 1'b0;
            zero_p3 <= 1'b0;
            g_p3    <= 1'b0;
            st_p3   <= 1'b0;
            exp_p3  <= '0;
            frac_p3 <= '0;
            vld_p4  <= 1'b0;
            res_p4  <= '0;
        end else if (advance) begin
            // p1: sign / magnitude / zero
            vld_p1  <= s_axis_a_tvalid;
            sign_p1 <= x[31];
            zero_p1 <= (x == 0);
            mag_p1  <= mag_in;
            // p2: leading-zero count
            vld_p2  <= vld_p1;
            sign_p2 <= sign_p1;
            zero_p2 <= zero_p1;
            mag_p2  <= mag_p1;
            lz_p2   <= clz(mag_p1);
            // p3: normalise, split into mantissa / guard / sticky
            vld_p3  <= vld_p2;
            sign_p3 <= sign_p2;
            zero_p3 <= zero_p2;
            exp_p3  <= 8'd158 - {3'd0, lz_p2};
            frac_p3 <= norm[30:8];
            g_p3    <= norm[7];
            st_p3   <= |norm[6:0];
            // p4: round and pack
            vld_p4  <= vld_p3;
            res_p4  <= round_pack(sign_p3, zero_p3, exp_p3, frac_p3, g_p3, st_p3);
        end
    end

    if (LATENCY > 4) begin : g_dly
        localparam int D = LATENCY - 4;
        logic [31:0] dly_data [D];
        logic        dly_vld  [D];

        always_ff @(posedge aclk or posedge aresetn) begin
            if (aresetn) begin
                for (int i = 0; i < D; i++) begin
                    dly_data[i] <= '0;
                    dly_vld[i]  <= 1'b0;
                end
            end else if (advance) begin
                dly_data[0] <= res_p4;
                dly_vld[0]  <= vld_p4;
                for (int i = 1; i < D; i++) begin
                    dly_data[i] <= dly_data[i-1];
                    dly_vld[i]  <= dly_vld[i-1];
                end
            end
        end

        assign out_data = dly_data[D-1];
        assign out_vld  = dly_vld[D-1];
    end else begin : g_nodly
        assign out_data = res_p4;
        assign out_vld  = vld_p4;
    end

    assign m_axis_result_tdata  = out_data;
    assign m_axis_result_tvalid = out_vld;

endmodule

// File: doc/fixed_to_float.md
# fixed_to_float

Pipelined converter from a 32-bit signed two's-complement integer to an IEEE-754 single-precision float, rounding to nearest, ties to even. It is the inverse of the float-to-fixed stage and sits on the same AXI-Stream style datapath, so the simulation model and the hardware share one handshake. It replaces the vendor int-to-float IP. Its fixed latency is configurable to match that IP cycle for cycle.

## Interface
- SIZE, 32: data width. Only 32 is supported; any other value is a configuration error.
- LATENCY, 7: total cycles from input acceptance to output valid. Must be >= 4: four compute stages, with delay stages padding the rest.
- aclk  in  1  clock; all state updates on the rising edge.
- aresetn  in  1  reset. Asynchronous, active-high despite the name: 1 clears, 0 runs.
- s_axis_a_tdata  in  SIZE  signed integer operand.
- s_axis_a_tvalid  in  1  operand valid.
- s_axis_a_tready  out  1  converter can accept an operand this cycle.
- m_axis_result_tdata  out  SIZE  float32 result bits.
- m_axis_result_tvalid  out  1  result valid.
- m_axis_result_tready  in  1  downstream accepts the result.

## Operation
- Reset, asynchronous:
  - all valid bits clear to 0; all data stages clear to 0.
  - outputs during and after reset: m_axis_result_tvalid=0, m_axis_result_tdata=0x00000000, s_axis_a_tready=1.
- Global-stall pipeline:
  - advance = m_axis_result_tready || !m_axis_result_tvalid.
  - s_axis_a_tready = advance, combinational.
  - When advance=1, every stage shifts by one. Stage 0 captures tdata, plus tvalid as its valid bit.
  - When advance=0, all stages hold.
  - Bubbles (tvalid=0) advance like data. Data in invalid slots is don't-care.
- Stage 1, sign/magnitude:
  - s = x[31].
  - mag = s ? -x : x, as a 32-bit unsigned value. x=0x80000000 gives mag=0x80000000.
  - zero flag = (x==0).
- Stage 2: lz = count of leading zeros of mag, a 5-bit value (only meaningful when mag != 0).
- Stage 3, normalise:
  - n = mag << lz, so n[31]=1.
  - exp = 127 + 31 - lz, in the range 127..158.
  - frac = n[30:8]; g = n[7]; st = |n[6:0].
- Stage 4, round:
  - up = g && (st || frac[0]).
  - {c,frac'} = frac + up.
  - If c=1, frac'=0 and exp=exp+1. The maximum exp is 159, so inf/NaN is never produced.
- Result:
  - zero flag → 0x00000000. Signed zero is never produced.
  - otherwise {s, exp[7:0], frac'}.
- Stages 5..LATENCY: pure delay registers carrying result and valid.
- There are no sideband, error or overflow outputs.

## Timing
- An operand handshaken in cycle n (tvalid && tready at the edge ending cycle n) produces m_axis_result_tvalid=1 with its result in cycle n+LATENCY, provided no stall occurs in between. Each stall cycle adds one cycle.
- Throughput is one result per cycle while m_axis_result_tready=1.
- Stall:
  - m_axis_result_tvalid=1 && m_axis_result_tready=0 → s_axis_a_tready=0 in the same cycle.
  - m_axis_result_tdata and m_axis_result_tvalid are held stable until the handshake.
  - No input is accepted or lost during a stall.
- tready may rise and fall freely; ordering is strictly FIFO.
- m_axis_result_tdata is a registered output (last stage); there is no combinational input→output path except advance → s_axis_a_tready.
- Reset mid-stream:
  - all in-flight operands are discarded.
  - m_axis_result_tvalid falls asynchronously at reset assertion.
  - the first operand accepted after release follows normal latency.

## Test plan
- Reset: assert aresetn mid-stream with 3 operands in flight → m_axis_result_tvalid=0, tdata=0 and s_axis_a_tready=1 immediately; no stale result appears after release.
- Exact values, tready=1 (each result at n+7):
  - 0 → 0x00000000
  - 1 → 0x3F800000
  - -1 → 0xBF800000
  - 100 → 0x42C80000
  - 0x80000000 → 0xCF000000
- Rounding:
  - 16777217 → 0x4B800000 (tie, even, down)
  - 16777219 → 0x4B800002 (tie, odd, up)
  - 0x7FFFFFFF → 0x4F000000 (mantissa carry into exponent)
- Throughput: 20 back-to-back operands 0..19 with tready=1 → 20 consecutive valid results in order, first in cycle n+7, no gaps.
- Backpressure: stream 0..9 with m_axis_result_tready randomly toggled ~50% → the exact sequence 0..9 converted with no loss or duplication; held tdata never changes while tvalid && !tready; s_axis_a_tready == (tready || !tvalid) every cycle.
- Bubbles: alternate s_axis_a_tvalid 1/0 → valid results alternate with invalid slots, each result 7 cycles after its input.
